// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 64 integer register file.
// Define REGFILE_BYPASS_EN to forward a pending write to matching read ports.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  // Highest index is XZR: no storage, reads 0, writes dropped
  localparam reg_addr_t ZERO_REG = reg_addr_t'(NUM_REGS - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  function automatic logic isZeroReg(reg_addr_t a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-side bundle of the register file: two read
// addresses with their buses, plus one write address/data/enable.
import regfile_pkg::*;

interface register_file_if #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [ADDR_WIDTH-1:0] RW;
  logic [DATA_WIDTH-1:0] BusW;
  logic                  RegWr;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;

  modport master (
    output RA,
    output RB,
    output RW,
    output BusW,
    output RegWr,
    input  BusA,
    input  BusB
  );

  modport slave (
    input  RA,
    input  RB,
    input  RW,
    input  BusW,
    input  RegWr,
    output BusA,
    output BusB
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: address decode, XZR override and,
// when REGFILE_BYPASS_EN is defined, forwarding of the pending write.
import regfile_pkg::*;

module register_file_read_port #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH - 1
) (
  input  logic [DATA_WIDTH-1:0] regs [DEPTH],
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [ADDR_WIDTH-1:0] ZeroReg = '1;

  logic isZero;
  logic fwdHit;

  assign isZero = (addr == ZeroReg);
  // wrEn already excludes XZR, so a hit never collides with isZero
  assign fwdHit = BYPASS_EN && wrEn && (addr == wrAddr);

  // XZR first, then forwarded write, else stored contents
  always_comb begin
    data = '0;
    if (isZero) begin
      data = '0;
    end else if (fwdHit) begin
      data = wrData;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64 register file: two async read ports, one write port that
// commits on the falling clock edge. Option macro: REGFILE_BYPASS_EN.
import regfile_pkg::*;

module register_file #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  register_file_if.slave   rf
);

  localparam int Depth = 2 ** ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ZeroReg = '1;

  logic [DATA_WIDTH-1:0] regs [Depth];
  logic                  wrHit;

  assign wrHit = rf.RegWr && (rf.RW != ZeroReg);

  // Falling-edge commit; reset clears storage at once and wins over a write
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else if (wrHit) begin
      regs[rf.RW] <= rf.BusW;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (Depth)
  ) u_portA (
    .regs   (regs),
    .addr   (rf.RA),
    .wrEn   (wrHit),
    .wrAddr (rf.RW),
    .wrData (rf.BusW),
    .data   (rf.BusA)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (Depth)
  ) u_portB (
    .regs   (regs),
    .addr   (rf.RB),
    .wrEn   (wrHit),
    .wrAddr (rf.RW),
    .wrData (rf.BusW),
    .data   (rf.BusB)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array model.
// Default build only (REGFILE_BYPASS_EN undefined).
module tb_register_file;

  logic Clk;
  logic Reset_n;

  register_file_if rf ();

  register_file dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .rf      (rf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [63:0] model [32];
  int nChecks;
  int nFails;

  function automatic logic [63:0] expRd(input int a);
    return (a == 31) ? 64'd0 : model[a];
  endfunction

  task automatic checkRd(input string name, input int a, input int b);
    rf.RA = 5'(a);
    rf.RB = 5'(b);
    #1;
    nChecks++;
    if (rf.BusA !== expRd(a)) begin
      nFails++;
      $display("FAIL %s BusA RA=%0d got %h exp %h", name, a, rf.BusA, expRd(a));
    end
    nChecks++;
    if (rf.BusB !== expRd(b)) begin
      nFails++;
      $display("FAIL %s BusB RB=%0d got %h exp %h", name, b, rf.BusB, expRd(b));
    end
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic en);
    @(posedge Clk);
    #1;
    rf.RW = 5'(a);
    rf.BusW = d;
    rf.RegWr = en;
    @(negedge Clk);
    #1;
    if (en && a != 31) model[a] = d;
    rf.RegWr = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    rf.RA = '0; rf.RB = '0; rf.RW = '0;
    rf.BusW = '0; rf.RegWr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    #12;
    for (int i = 0; i < 32; i += 5) checkRd("reset", i, 31 - i);
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic test_zero_reg;
    checkRd("xzr_read", 31, 31);
    wr(31, 64'h12345678, 1'b1);
    checkRd("xzr_write", 31, 31);
  endtask

  task automatic test_fill;
    for (int n = 0; n < 31; n++) wr(n, 64'(n), 1'b1);
    checkRd("fill01", 0, 1);
    checkRd("fill23", 2, 3);
    checkRd("fill30", 30, 15);
  endtask

  task automatic test_write_disable;
    wr(1, 64'h1000, 1'b0);
    checkRd("wr_dis", 1, 0);
  endtask

  task automatic test_writes_then_reads;
    rf.RA = 5'd6;
    rf.RB = 5'd7;
    wr(10, 64'h1010, 1'b1);
    checkRd("wtr_hold1", 6, 7);
    wr(11, 64'h103000, 1'b1);
    checkRd("wtr_hold2", 6, 7);
    checkRd("wtr_read", 10, 11);
    nChecks++;
    if (rf.BusA !== 64'h1010 || rf.BusB !== 64'h103000) begin
      nFails++;
      $display("FAIL wtr_const got %h %h exp 1010 103000", rf.BusA, rf.BusB);
    end
  endtask

  task automatic test_same_addr;
    @(posedge Clk);
    #1;
    rf.RB = 5'd13;
    rf.RW = 5'd13;
    rf.BusW = 64'habcd;
    rf.RegWr = 1'b1;
    #1;
    nChecks++;
    if (rf.BusB !== 64'd13) begin
      nFails++;
      $display("FAIL same_before got %h exp %h", rf.BusB, 64'd13);
    end
    @(negedge Clk);
    #1;
    nChecks++;
    if (rf.BusB !== 64'habcd) begin
      nFails++;
      $display("FAIL same_after got %h exp %h", rf.BusB, 64'habcd);
    end
    model[13] = 64'habcd;
    rf.RegWr = 1'b0;
    wr(14, 64'h9080009, 1'b0);
    checkRd("same_nowr", 14, 13);
  endtask

  task automatic test_random;
    logic [63:0] d;
    int a, b, w;
    logic en;
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(31);
      b = $urandom_range(31);
      w = $urandom_range(31);
      en = 1'($urandom);
      d = {$urandom, $urandom};
      @(posedge Clk);
      #1;
      rf.RW = 5'(w);
      rf.BusW = d;
      rf.RegWr = en;
      checkRd("rand_pre", a, b);
      @(negedge Clk);
      #1;
      if (en && w != 31) model[w] = d;
      checkRd("rand_post", a, b);
      rf.RegWr = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    logic [63:0] d;
    for (int n = 0; n < 31; n++) wr(n, {$urandom, $urandom} | 64'd1, 1'b1);
    checkRd("prefill", 5, 30);
    @(posedge Clk);
    #2;
    d = {$urandom, $urandom} | 64'd1;
    rf.RW = 5'd5;
    rf.BusW = d;
    rf.RegWr = 1'b1;
    Reset_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    for (int i = 0; i < 32; i++) checkRd("arst_now", i, 31 - i);
    @(negedge Clk);
    #1;
    checkRd("arst_drop", 5, 5);
    #1;
    Reset_n = 1'b1;
    checkRd("arst_release", 5, 0);
    @(negedge Clk);
    #1;
    model[5] = d;
    checkRd("arst_after", 5, 4);
    rf.RegWr = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    test_reset();
    test_zero_reg();
    test_fill();
    test_write_disable();
    test_writes_then_reads();
    test_same_addr();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 64-bit integer register file for the single-cycle CPU datapath, between instruction decode and the ALU/writeback stage. It provides two asynchronous (combinational) read ports and one write port that commits on the falling edge of the clock. Register 31 is the hardwired zero register (XZR): it always reads 0 and ignores writes.

## Interface
- Clocking and reset: one clock; reset is asynchronous and active-low (`Clk`, `Reset_n`).
- Parameters:
  - `DATA_WIDTH`, default 64: register and bus width.
  - `ADDR_WIDTH`, default 5: register index width (2^ADDR_WIDTH entries).
- Ports:
  - `Clk` input, 1 bit: write clock; writes commit on the falling edge.
  - `Reset_n` input, 1 bit: asynchronous active-low clear of all registers.
  - `RA` input, 5 bits: read address, port A.
  - `RB` input, 5 bits: read address, port B.
  - `RW` input, 5 bits: write address.
  - `BusW` input, 64 bits: write data.
  - `RegWr` input, 1 bit: write enable.
  - `BusA` output, 64 bits: contents of register `RA`.
  - `BusB` output, 64 bits: contents of register `RB`.

## Operation
- Storage: registers 0..30 are physical 64-bit registers. Register 31 has no storage.
- Read:
  - `BusA = (RA==31) ? 0 : reg[RA]`; `BusB = (RB==31) ? 0 : reg[RB]`.
  - Purely combinational; the two ports are fully independent; `RA==RB` is allowed.
- Write:
  - On the falling edge of `Clk`, if `RegWr==1` and `RW!=31`, then `reg[RW] <= BusW`.
  - `RegWr==0`: no register changes, whatever `RW`/`BusW` are.
  - `RW==31` with `RegWr==1`: the write is discarded silently.
- Register 0 is an ordinary writable register.
- Read during write to the same address (build without the bypass macro):
  - Before the falling edge, the read port shows the old value.
  - After the falling edge, it shows the new value.

## Timing
- Reset:
  - `Reset_n` low clears registers 0..30 to 0 immediately (asynchronous), independent of `Clk`.
  - Reset dominates a coincident write.
  - Releasing reset mid-cycle causes no spurious write; the next qualifying falling edge writes normally.
- Reset value of outputs: `BusA = BusB = 0` for any address.
- Write latency: a value presented with `RegWr=1` is visible on a read port directly after the falling edge, within the same high/low clock cycle.
- Read latency: zero cycles, combinational from `RA`/`RB` and storage.
- The rising edge of `Clk` has no effect.

## Configuration
- Macro `REGFILE_BYPASS_EN`:
  - Defined: write-to-read forwarding. When `RegWr==1` and `RW!=31`, any read port whose address equals `RW` outputs `BusW` combinationally before the edge.
  - Not defined (default): reads always show stored contents, as described in Operation.
- The test plan assumes the macro is not defined.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_WIDTH`, `ADDR_WIDTH`, `NUM_REGS`
  - `ZERO_REG = 5'd31`
  - typedefs `reg_data_t` (64 bits) and `reg_addr_t` (5 bits)
- One sub-module is natural: `register_file_read_port`, instantiated twice. It holds the address decode, the zero-register override and the optional bypass mux.
- Storage array and write logic stay in the top module.

## Test plan
1. Zero register:
   - Reset, then `RA=RB=31` gives `BusA=BusB=0`.
   - Write `RW=31`, `BusW=0x12345678`, `RegWr=1`, then a falling edge: `BusA`/`BusB` are still 0.
2. Fill:
   - For n=0..30, write `RW=n`, `BusW=n`, `RegWr=1`, each with a falling edge.
   - Then `RA=0,RB=1` gives 0 and 1; `RA=2,RB=3` gives 2 and 3.
3. Write disable: `RW=1`, `BusW=0x1000`, `RegWr=0`, falling edge: `RA=1` still reads 1.
4. Writes then reads:
   - Write reg10=0x1010, then reg11=0x103000, while reading `RA=6,RB=7`: the bus shows 6 and 7 throughout.
   - Then `RA=10,RB=11` gives 0x1010 and 0x103000.
5. Same-address timing:
   - `RB=13`, `RW=13`, `BusW=0xabcd`, `RegWr=1`: `BusB=13` before the falling edge and 0xabcd after it.
   - `RW=14`, `RegWr=0`, `BusW=0x9080009`: reg14 stays 14.
6. Asynchronous reset:
   - With registers filled, pulse `Reset_n` low between clock edges: every `RA`/`RB` reads 0 immediately.
   - A write pending at the same time is dropped.
